// File: rtl/mau_pkg.sv
// mau_pkg: access-size encodings, FSM states, lane widths and address helpers for mem_access_unit.
package mau_pkg;
   typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;
   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;
   function automatic size_e norm_size(input logic [1:0] s);
      return s == SZ_RSVD ? SZ_WORD : size_e'(s);
   endfunction
   function automatic logic misaligned(input size_e s, input logic [1:0] lo);
      return (s == SZ_HALF && lo[0]) || (s == SZ_WORD && lo != 2'b00);
   endfunction
   function automatic logic [1:0] align_lo(input size_e s, input logic [1:0] lo);
      return s == SZ_WORD ? 2'b00 : s == SZ_HALF ? {lo[1], 1'b0} : lo;
   endfunction
endpackage

// File: rtl/mau_align.sv
// mau_align: little-endian lane extract (with zero/sign extension) and sub-word merge into a RAM word.
module mau_align
   import mau_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [1:0]        addr,
   input  size_e             size,
   input  logic              sgn,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] load,
   output logic [WORD_W-1:0] merged
);
   logic [4:0]        sh;
   logic [HALF_W-1:0] lane;
   logic [WORD_W-1:0] mask;
   always_comb begin
      sh = size == SZ_HALF ? {addr[1], 4'b0000} : {addr, 3'b000};
      lane = HALF_W'(word >> sh);
      mask = size == SZ_HALF ? 32'h0000_ffff : 32'h0000_00ff;
      load = size == SZ_BYTE ? {{(WORD_W-BYTE_W){sgn & lane[BYTE_W-1]}}, lane[BYTE_W-1:0]} :
             size == SZ_HALF ? {{(WORD_W-HALF_W){sgn & lane[HALF_W-1]}}, lane} : word;
      merged = size == SZ_WORD ? wdata : (word & ~(mask << sh)) | ((wdata & mask) << sh);
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding CPU load/store unit over a word RAM with read-modify-write for sub-word stores.
// Define MISALIGN_TRAP_EN to trap misaligned requests (Rsp_err) instead of force-aligning them.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Req_valid,
   output logic              Req_ready,
   input  logic              Req_we,
   input  logic [1:0]        Req_size,
   input  logic              Req_signed,
   input  logic [ADDR_W-1:0] Req_addr,
   input  logic [DATA_W-1:0] Req_wdata,
   output logic              Rsp_valid,
   output logic [DATA_W-1:0] Rsp_rdata,
   output logic              Rsp_err,
   output logic [ADDR_W-1:0] Mem_addr,
   output logic [DATA_W-1:0] Mem_din,
   output logic              Mem_we,
   input  logic [DATA_W-1:0] Mem_dout
);
   state_e            state, next;
   size_e             size_q, size_in;
   logic              we_q, sgn_q, trap, word_wr;
   logic [ADDR_W-1:0] addr_q, addr_in;
   logic [DATA_W-1:0] wdata_q, rdata_q, merged_q, load, merged;
   assign size_in = norm_size(Req_size);
`ifdef MISALIGN_TRAP_EN
   logic trap_q;
   assign addr_in = Req_addr;
   assign trap = trap_q;
   always_ff @(posedge Clk)
      if (!Rst_n) trap_q <= 1'b0;
      else if (Req_valid && Req_ready) trap_q <= misaligned(size_in, Req_addr[1:0]);
`else
   assign addr_in = {Req_addr[ADDR_W-1:2], align_lo(size_in, Req_addr[1:0])};
   assign trap = 1'b0;
`endif
   mau_align u_align (
      .word(Mem_dout), .addr(addr_q[1:0]), .size(size_q), .sgn(sgn_q), .wdata(wdata_q),
      .load(load), .merged(merged)
   );
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state    <= IDLE;
         we_q     <= 1'b0;
         sgn_q    <= 1'b0;
         size_q   <= SZ_BYTE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         merged_q <= '0;
      end else begin
         state <= next;
         if (Req_valid && Req_ready) begin
            we_q    <= Req_we;
            sgn_q   <= Req_signed;
            size_q  <= size_in;
            addr_q  <= addr_in;
            wdata_q <= Req_wdata;
         end
         if (state == ACCESS) begin
            rdata_q  <= we_q || trap ? '0 : load;
            merged_q <= merged;
         end
      end
   end
   // Mem_we is gated by Rst_n so a reset in the write cycle suppresses that write.
   always_comb begin
      next      = state;
      word_wr   = state == ACCESS && !trap && we_q && size_q == SZ_WORD;
      Req_ready = state == IDLE;
      Mem_we    = Rst_n && (word_wr || state == WRITE);
      Mem_addr  = (state == ACCESS && !trap) || state == WRITE ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
      Mem_din   = state == WRITE ? merged_q : word_wr ? wdata_q : '0;
      Rsp_valid = state == RESP;
      Rsp_rdata = Rsp_valid ? rdata_q : '0;
      Rsp_err   = Rsp_valid && trap;
      case (state)
         IDLE:    next = Req_valid ? ACCESS : IDLE;
         ACCESS:  next = !trap && we_q && size_q != SZ_WORD ? WRITE : RESP;
         WRITE:   next = RESP;
         default: next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit against a word RAM model; honours MISALIGN_TRAP_EN.
module tb_mem_access_unit;
   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Req_valid = 1'b0, Req_we = 1'b0, Req_signed = 1'b0;
   logic [1:0]  Req_size = 2'b00;
   logic [31:0] Req_addr = '0, Req_wdata = '0;
   logic        Req_ready, Rsp_valid, Rsp_err, Mem_we;
   logic [31:0] Rsp_rdata, Mem_addr, Mem_din, Mem_dout;
   logic [31:0] ram [0:63];
   logic        pre_en = 1'b0;
   logic [5:0]  pre_idx = '0;
   logic [31:0] pre_val = '0;
   int checks = 0, failures = 0;
   typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
   exp_t sb[$];

   always #5 Clk = ~Clk;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_we(Req_we),
      .Req_size(Req_size), .Req_signed(Req_signed), .Req_addr(Req_addr), .Req_wdata(Req_wdata),
      .Rsp_valid(Rsp_valid), .Rsp_rdata(Rsp_rdata), .Rsp_err(Rsp_err), .Mem_addr(Mem_addr),
      .Mem_din(Mem_din), .Mem_we(Mem_we), .Mem_dout(Mem_dout)
   );

   assign Mem_dout = ram[Mem_addr[7:2]];
   always @(posedge Clk)
      if (Mem_we) ram[Mem_addr[7:2]] <= Mem_din;
      else if (pre_en) ram[pre_idx] <= pre_val;

   task automatic preset(input int idx, input logic [31:0] val);
      @(negedge Clk);
      pre_en = 1'b1; pre_idx = 6'(idx); pre_val = val;
      @(negedge Clk);
      pre_en = 1'b0;
   endtask

   task automatic do_req(input string name, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat, input int exp_wr,
                         input logic [31:0] exp_maddr, input logic [31:0] exp_din);
      exp_t e;
      int lat = 0, wr = 0;
      logic done = 1'b0;
      logic [31:0] din_seen = '0, addr_seen = '0;
      e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
      sb.push_back(e);
      @(negedge Clk);
      Req_valid = 1'b1; Req_we = we; Req_size = size; Req_signed = sgn; Req_addr = addr; Req_wdata = wdata;
      checks++;
      if (Req_ready !== 1'b1) begin failures++; $display("FAIL %s ready_at_accept got=%b exp=1", name, Req_ready); end
      while (!done && lat < 8) begin
         @(negedge Clk);
         lat++;
         Req_valid = 1'b0; Req_we = ~we; Req_signed = ~sgn;
         Req_size = 2'($urandom()); Req_addr = $urandom(); Req_wdata = $urandom();
         checks++;
         if (Req_ready !== 1'b0) begin failures++; $display("FAIL %s ready_busy cyc=%0d got=%b exp=0", name, lat, Req_ready); end
         if (Mem_we === 1'b1) begin wr++; din_seen = Mem_din; addr_seen = Mem_addr; end
         if (Rsp_valid === 1'b1) begin
            done = 1'b1;
            e = sb.pop_front();
            checks++;
            if (Rsp_rdata !== e.rdata) begin failures++; $display("FAIL %s rdata got=%h exp=%h", name, Rsp_rdata, e.rdata); end
            checks++;
            if (Rsp_err !== e.err) begin failures++; $display("FAIL %s err got=%b exp=%b", name, Rsp_err, e.err); end
            checks++;
            if (lat != e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, e.lat); end
         end
      end
      checks++;
      if (!done) begin failures++; void'(sb.pop_front()); $display("FAIL %s timeout no Rsp_valid", name); end
      checks++;
      if (wr != exp_wr) begin failures++; $display("FAIL %s write_count got=%0d exp=%0d", name, wr, exp_wr); end
      if (exp_wr > 0) begin
         checks++;
         if (din_seen !== exp_din) begin failures++; $display("FAIL %s mem_din got=%h exp=%h", name, din_seen, exp_din); end
         checks++;
         if (addr_seen !== exp_maddr) begin failures++; $display("FAIL %s mem_addr got=%h exp=%h", name, addr_seen, exp_maddr); end
      end
   endtask

   task automatic test_reset;
      Rst_n = 1'b0;
      repeat (2) @(negedge Clk);
      checks++;
      if ({Req_ready, Rsp_valid, Rsp_err, Mem_we} !== 4'b1000) begin
         failures++; $display("FAIL reset ready/valid/err/we got=%b exp=1000", {Req_ready, Rsp_valid, Rsp_err, Mem_we});
      end
      checks++;
      if (Rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset rdata got=%h exp=0", Rsp_rdata); end
      checks++;
      if (Mem_addr !== 32'h0) begin failures++; $display("FAIL reset mem_addr got=%h exp=0", Mem_addr); end
      checks++;
      if (Mem_din !== 32'h0) begin failures++; $display("FAIL reset mem_din got=%h exp=0", Mem_din); end
      Rst_n = 1'b1;
   endtask

   task automatic test_word_store_load;
      do_req("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hdeadbeef, 32'h0, 1'b0, 2, 1, 32'h10, 32'hdeadbeef);
      do_req("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hdeadbeef, 1'b0, 2, 0, 32'h0, 32'h0);
   endtask

   task automatic test_subword_store;
      do_req("st_byte", 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0055, 32'h0, 1'b0, 3, 1, 32'h10, 32'hde55beef);
      do_req("st_half", 1'b1, 2'b01, 1'b0, 32'h10, 32'h1234_a5a5, 32'h0, 1'b0, 3, 1, 32'h10, 32'hde55a5a5);
      do_req("ld_after_sub", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hde55a5a5, 1'b0, 2, 0, 32'h0, 32'h0);
   endtask

   task automatic test_load_ext;
      preset(8, 32'h80f0_7f81);
      do_req("ld_b_s",    1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'hffffff81, 1'b0, 2, 0, 32'h0, 32'h0);
      do_req("ld_b_u",    1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h00000081, 1'b0, 2, 0, 32'h0, 32'h0);
      do_req("ld_h_s",    1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hffff80f0, 1'b0, 2, 0, 32'h0, 32'h0);
      do_req("ld_h_u",    1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h000080f0, 1'b0, 2, 0, 32'h0, 32'h0);
      do_req("ld_b1_s",   1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000007f, 1'b0, 2, 0, 32'h0, 32'h0);
      do_req("ld_b3_s",   1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'hffffff80, 1'b0, 2, 0, 32'h0, 32'h0);
      do_req("ld_h0_s",   1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h00007f81, 1'b0, 2, 0, 32'h0, 32'h0);
      do_req("ld_rsvd",   1'b0, 2'b11, 1'b1, 32'h20, 32'h0, 32'h80f07f81, 1'b0, 2, 0, 32'h0, 32'h0);
   endtask

   task automatic test_misaligned;
`ifdef MISALIGN_TRAP_EN
      do_req("mis_st_word", 1'b1, 2'b10, 1'b0, 32'h13, 32'h11223344, 32'h0, 1'b1, 2, 0, 32'h0, 32'h0);
      do_req("mis_ld_chk",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hde55a5a5, 1'b0, 2, 0, 32'h0, 32'h0);
      do_req("mis_ld_half", 1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 32'h0, 1'b1, 2, 0, 32'h0, 32'h0);
      do_req("mis_st_half", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000beef, 32'h0, 1'b1, 2, 0, 32'h0, 32'h0);
`else
      do_req("mis_st_word", 1'b1, 2'b10, 1'b0, 32'h13, 32'h11223344, 32'h0, 1'b0, 2, 1, 32'h10, 32'h11223344);
      do_req("mis_ld_chk",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 2, 0, 32'h0, 32'h0);
      do_req("mis_ld_half", 1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 32'h00007f81, 1'b0, 2, 0, 32'h0, 32'h0);
      do_req("mis_st_half", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000beef, 32'h0, 1'b0, 3, 1, 32'h10, 32'h1122beef);
`endif
   endtask

   task automatic test_reset_mid_write;
      int seen = 0;
      preset(12, 32'hdeadbeef);
      @(negedge Clk);
      Req_valid = 1'b1; Req_we = 1'b1; Req_size = 2'b00; Req_signed = 1'b0; Req_addr = 32'h32; Req_wdata = 32'h55;
      checks++;
      if (Req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid ready_at_accept got=%b exp=1", Req_ready); end
      @(negedge Clk);
      Req_valid = 1'b0;
      checks++;
      if (Mem_we !== 1'b0) begin failures++; $display("FAIL rst_mid we_in_access got=%b exp=0", Mem_we); end
      @(negedge Clk);
      checks++;
      if (Mem_we !== 1'b1 || Mem_din !== 32'hde55beef) begin
         failures++; $display("FAIL rst_mid write_cycle we=%b din=%h exp we=1 din=de55beef", Mem_we, Mem_din);
      end
      Rst_n = 1'b0;
      @(negedge Clk);
      checks++;
      if ({Mem_we, Rsp_valid, Req_ready} !== 3'b001) begin
         failures++; $display("FAIL rst_mid after_reset we/valid/ready got=%b exp=001", {Mem_we, Rsp_valid, Req_ready});
      end
      Rst_n = 1'b1;
      repeat (4) begin
         @(negedge Clk);
         if (Rsp_valid !== 1'b0 || Mem_we !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL rst_mid late_activity got=%0d exp=0", seen); end
      do_req("rst_mid_ram", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hdeadbeef, 1'b0, 2, 0, 32'h0, 32'h0);
   endtask

   task automatic test_back_to_back;
      exp_t e;
      preset(9, 32'h1357_9bdf);
      e.err = 1'b0; e.lat = 2;
      e.rdata = 32'h80f07f81; sb.push_back(e);
      e.rdata = 32'h13579bdf; sb.push_back(e);
      @(negedge Clk);
      Req_valid = 1'b1; Req_we = 1'b0; Req_size = 2'b10; Req_signed = 1'b0; Req_addr = 32'h20;
      checks++;
      if (Req_ready !== 1'b1) begin failures++; $display("FAIL b2b ready c=0 got=%b exp=1", Req_ready); end
      for (int c = 1; c <= 6; c++) begin
         @(negedge Clk);
         if (c == 1) Req_addr = 32'h24;
         if (c == 4) Req_valid = 1'b0;
         checks++;
         if (Req_ready !== (c % 3 == 0)) begin failures++; $display("FAIL b2b ready c=%0d got=%b exp=%b", c, Req_ready, c % 3 == 0); end
         checks++;
         if (Rsp_valid !== (c == 2 || c == 5)) begin failures++; $display("FAIL b2b rsp_valid c=%0d got=%b", c, Rsp_valid); end
         if (Rsp_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (Rsp_rdata !== e.rdata) begin failures++; $display("FAIL b2b rdata c=%0d got=%h exp=%h", c, Rsp_rdata, e.rdata); end
         end
      end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL b2b responses_missing got=%0d exp=0", sb.size()); sb.delete(); end
   endtask

   initial begin
      test_reset();
      test_word_store_load();
      test_subword_store();
      test_load_ext();
      test_misaligned();
      test_reset_mid_write();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
